div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_sign_fix.sv | 47 ++++
 rtl/div_unit.sv | 168 ++++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the div_unit divider
package div_pkg;

    // Default operand width of the divider.
    localparam int DIV_WIDTH_DEFAULT = 32;

    // Iteration counter width for a given operand width; the counter
    // runs 0 .. width-1 during BUSY.
    function automatic int div_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Iteration-counter width for the default operand width.
    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - absolute-value operand conversion and quotient/remainder sign correction
//
// Purely combinational.
// Ports:
//   i_signed_div   1 = signed divide
//   i_a, i_b       raw dividend / divisor
//   o_abs_a/b      magnitudes fed to the unsigned iterative core
//   o_neg_q        quotient must be negated (operand signs differ)
//   o_neg_r        remainder must be negated (dividend negative)
//   i_neg_q/r      sign flags captured at start, applied to the raw result
//   i_q_raw/r_raw  unsigned quotient/remainder from the core
//   o_q, o_r       sign-corrected quotient/remainder
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             i_signed_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_abs_a,
    output logic [WIDTH-1:0] o_abs_b,
    output logic             o_neg_q,
    output logic             o_neg_r,
    input  logic             i_neg_q,
    input  logic             i_neg_r,
    input  logic [WIDTH-1:0] i_q_raw,
    input  logic [WIDTH-1:0] i_r_raw,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r
);

    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = i_signed_div & i_a[WIDTH-1];
    assign w_b_neg = i_signed_div & i_b[WIDTH-1];

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the
    // correct magnitude, so the most-negative case needs no special path.
    assign o_abs_a = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign o_abs_b = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign o_neg_q = w_a_neg ^ w_b_neg;
    assign o_neg_r = w_a_neg;

    assign o_q = i_neg_q ? (~i_q_raw + 1'b1) : i_q_raw;
    assign o_r = i_neg_r ? (~i_r_raw + 1'b1) : i_r_raw;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring DIV/DIVU unit with pipeline stall handshake
//
// Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero skips BUSY).
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        DIV/DIVU request (level), with signed_div, a, b sampled in IDLE
//   cancel       flush; forces IDLE next edge, beats start
//   stall        front-end hold
//   done         one-cycle result-valid pulse
//   result       {remainder, quotient}, updated only on entry to DONE
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               stall,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int               CNT_W     = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;     // dividend shifts out the top, quotient bits in the bottom
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [2*WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_zero_fast;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg_q;
    logic             w_neg_r;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept = (r_state == IDLE) & start & ~cancel;
    assign w_last   = (r_cnt == LAST_ITER);

`ifdef DIV_ZERO_FAST_EN
    assign w_zero_fast = (b == '0);
`else
    assign w_zero_fast = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The low WIDTH bits of the difference are exact whenever it fits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_nxt = w_fits ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

    div_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .i_signed_div (signed_div),
        .i_a          (a),
        .i_b          (b),
        .o_abs_a      (w_abs_a),
        .o_abs_b      (w_abs_b),
        .o_neg_q      (w_neg_q),
        .o_neg_r      (w_neg_r),
        .i_neg_q      (r_neg_q),
        .i_neg_r      (r_neg_r),
        .i_q_raw      (w_quo_nxt),
        .i_r_raw      (w_rem_nxt),
        .o_q          (w_q_fix),
        .o_r          (w_r_fix)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (cancel) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = w_zero_fast ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        case (r_state)
            IDLE:    stall = start & ~cancel;
            BUSY:    stall = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    assign result = r_result;

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_cnt   <= '0;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            if (w_zero_fast) begin
                r_result <= {a, {WIDTH{1'b1}}};
            end
        end else if ((r_state == BUSY) && !cancel) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= {w_r_fix, w_q_fix};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall;
    logic        done;
    logic [63:0] result;

    int vectors;
    int miscompares;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall      (stall),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure edges from acceptance to the done cycle
    // and count stall cycles (including the combinational start cycle).
    task automatic run_div(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
        int edges;
        int stalls;
        bit got;
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        a          = av;
        b          = bv;
        #1;
        stalls = stall ? 1 : 0;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 1;
        got   = 1'b0;
        while (!got && edges < 200) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (stall) stalls++;
                @(posedge clk);
                edges++;
            end
        end
        check_val({tag, ".done"}, 64'(got), 64'd1);
        check_val({tag, ".lat"}, 64'(edges), 64'(exp_lat));
        check_val({tag, ".stall"}, 64'(stalls), 64'(exp_lat));
        check_val({tag, ".result"}, result, exp);
        @(negedge clk);
        check_val({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        signed_div  = 1'b0;
        a           = '0;
        b           = '0;
        cancel      = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst.stall", 64'(stall), 64'd0);
        check_val("rst.done", 64'(done), 64'd0);
        check_val("rst.result", result, 64'd0);
        rst = 1'b1;

        // start together with cancel is not accepted
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        a      = 32'd100;
        b      = 32'd7;
        #1 check_val("startcancel.stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 begin start = 1'b0; cancel = 1'b0; end
        @(negedge clk);
        check_val("startcancel.idle", 64'(stall), 64'd0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZERO_LAT);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        run_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 33);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
        run_div("divu_max_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, {32'h7FFF_FFFF, 32'd1}, 33);

        // cancel at BUSY cycle 10: previous result must survive
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        a          = 32'd100;
        b          = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check_val("cancel.busy_stall", 64'(stall), 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check_val("cancel.stall", 64'(stall), 64'd0);
        watch_no_done("cancel.no_done", 40);
        check_val("cancel.result", result, {32'h7FFF_FFFF, 32'd1});

        // reset at BUSY cycle 5
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst.stall", 64'(stall), 64'd0);
        check_val("midrst.result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        watch_no_done("midrst.no_done", 40);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
